// File: rtl/dmem_wishbone_if.sv
// Data-side Wishbone-classic master behind the MEM stage: one outstanding access,
// pipeline stall request, read-data hold while frozen, and a timeout abort.
module dmem_wishbone_if #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_ce_i,
  input  logic                  cpu_we_i,
  input  logic [DATA_W-1:0]     cpu_addr_i,
  input  logic [DATA_W/8-1:0]   cpu_sel_i,
  input  logic [DATA_W-1:0]     cpu_data_i,
  output logic [DATA_W-1:0]     cpu_data_o,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic                  stallreq_o,
  output logic                  bus_err_o,
  output logic [DATA_W-1:0]     wb_adr_o,
  output logic [DATA_W-1:0]     wb_dat_o,
  input  logic [DATA_W-1:0]     wb_dat_i,
  output logic [DATA_W/8-1:0]   wb_sel_o,
  output logic                  wb_we_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  input  logic                  wb_ack_i
);

  // Handshake: a transfer completes in any BUSY cycle where cyc&stb are high and
  // wb_ack_i is sampled high; the request is held stable until then.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BUSY       = 2'd1,
    WAIT_STALL = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [DATA_W-1:0]     adr_q, adr_d;
  logic [DATA_W-1:0]     dat_q, dat_d;
  logic [DATA_W/8-1:0]   sel_q, sel_d;
  logic                  we_q, we_d;
  logic                  cyc_q, cyc_d;
  logic                  stb_q, stb_d;
  logic [DATA_W-1:0]     rd_buf_q, rd_buf_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  bus_err_q, bus_err_d;
  logic                  release_bus;

  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    we_d        = we_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    rd_buf_d    = rd_buf_q;
    cnt_d       = cnt_q;
    bus_err_d   = 1'b0;
    release_bus = 1'b0;
    stallreq_o  = 1'b0;
    cpu_data_o  = '0;

    case (state_q)
      IDLE: begin
        if (cpu_ce_i && !flush_i) begin
          adr_d      = cpu_addr_i;
          dat_d      = cpu_data_i;
          sel_d      = cpu_sel_i;
          we_d       = cpu_we_i;
          cyc_d      = 1'b1;
          stb_d      = 1'b1;
          cnt_d      = '0;
          state_d    = BUSY;
          stallreq_o = 1'b1;
        end
      end
      BUSY: begin
        if (wb_ack_i && !we_q) begin
          cpu_data_o = wb_dat_i;
        end
        // Flush beats ack: the instruction is being discarded anyway.
        if (flush_i) begin
          release_bus = 1'b1;
          state_d     = IDLE;
        end else if (wb_ack_i) begin
          release_bus = 1'b1;
          rd_buf_d    = we_q ? '0 : wb_dat_i;
          state_d     = stall_i ? WAIT_STALL : IDLE;
        end else if (cnt_q == TO_LAST) begin
          release_bus = 1'b1;
          rd_buf_d    = '0;
          bus_err_d   = 1'b1;
          state_d     = stall_i ? WAIT_STALL : IDLE;
        end else begin
          cnt_d      = cnt_q + CNT_W'(1);
          stallreq_o = 1'b1;
        end
      end
      WAIT_STALL: begin
        cpu_data_o = rd_buf_q;
        if (flush_i || !stall_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (release_bus) begin
      adr_d = '0;
      dat_d = '0;
      sel_d = '0;
      we_d  = 1'b0;
      cyc_d = 1'b0;
      stb_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      rd_buf_q  <= '0;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      rd_buf_q  <= rd_buf_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign wb_sel_o  = sel_q;
  assign wb_we_o   = we_q;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = stb_q;
  assign bus_err_o = bus_err_q;

endmodule

// File: tb/tb_dmem_wishbone_if.sv
// Bench for dmem_wishbone_if: directed accesses, expected completions queued by the
// stimulus and checked by an independent monitor on each ack / bus error.
module tb_dmem_wishbone_if;

  localparam int S_IDLE = 0;
  localparam int S_BUSY = 1;
  localparam int S_WAIT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ce_i, cpu_we_i;
  logic [31:0] cpu_addr_i, cpu_data_i, cpu_data_o;
  logic [3:0]  cpu_sel_i;
  logic        stall_i, flush_i, stallreq_o, bus_err_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i;

  always #5 clk = ~clk;

  dmem_wishbone_if #(.DATA_W(32), .TIMEOUT(4), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_ce_i   (cpu_ce_i),
    .cpu_we_i   (cpu_we_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_sel_i  (cpu_sel_i),
    .cpu_data_i (cpu_data_i),
    .cpu_data_o (cpu_data_o),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .stallreq_o (stallreq_o),
    .bus_err_o  (bus_err_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_sel_o   (wb_sel_o),
    .wb_we_o    (wb_we_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_ack_i   (wb_ack_i)
  );

  typedef struct packed {
    logic        err;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic [31:0] rdat;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%08h required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every completion seen on the bus retires the oldest expected entry.
  always @(negedge clk) begin
    if (rst && wb_cyc_o && wb_stb_o && wb_ack_i && !flush_i) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL mon_unexpected_ack: actual ack required none at %0t", $time);
      end else begin
        m_e = exp_q.pop_front();
        chk("mon_is_ack", {31'd0, m_e.err}, 32'd0);
        chk("mon_adr", wb_adr_o, m_e.adr);
        chk("mon_sel", {28'd0, wb_sel_o}, {28'd0, m_e.sel});
        chk("mon_we", {31'd0, wb_we_o}, {31'd0, m_e.we});
        chk("mon_wdat", wb_dat_o, m_e.wdat);
        chk("mon_rdata", cpu_data_o, m_e.we ? 32'd0 : m_e.rdat);
        chk("mon_stallreq", {31'd0, stallreq_o}, 32'd0);
      end
    end
    if (bus_err_o) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL mon_unexpected_err: actual bus_err required none at %0t", $time);
      end else begin
        m_e = exp_q.pop_front();
        chk("mon_is_err", {31'd0, m_e.err}, 32'd1);
      end
    end
  end

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] wdat, input int wait_n, input logic [31:0] rdat,
                        input logic stall_at_ack);
    int sreq = 0;
    exp_q.push_back('{err: 1'b0, we: we, adr: adr, sel: sel, wdat: wdat, rdat: rdat});
    next_cyc;
    wb_ack_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = adr; cpu_sel_i = sel; cpu_data_i = wdat;
    @(negedge clk);
    chk("req_cyc_low", {31'd0, wb_cyc_o}, 32'd0);
    sreq += int'(stallreq_o);
    for (int i = 0; i < wait_n; i++) begin
      next_cyc;
      wb_dat_i = $urandom;
      @(negedge clk);
      chk("busy_stb", {31'd0, wb_stb_o}, 32'd1);
      chk("busy_adr", wb_adr_o, adr);
      chk("busy_sel", {28'd0, wb_sel_o}, {28'd0, sel});
      chk("busy_we", {31'd0, wb_we_o}, {31'd0, we});
      chk("busy_dat", wb_dat_o, wdat);
      sreq += int'(stallreq_o);
    end
    next_cyc;
    wb_ack_i = 1'b1; wb_dat_i = rdat; stall_i = stall_at_ack;
    @(negedge clk);
    sreq += int'(stallreq_o);
    chk("stallreq_cycles", sreq, wait_n + 1);
  endtask

  task automatic idle_check;
    next_cyc;
    wb_ack_i = 1'b0; cpu_ce_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    wb_dat_i = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("idle_state", dut.state_q, S_IDLE);
    chk("idle_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("idle_stb", {31'd0, wb_stb_o}, 32'd0);
    chk("idle_data", cpu_data_o, 32'd0);
    chk("idle_stallreq", {31'd0, stallreq_o}, 32'd0);
  endtask

  task automatic wait_stall(input int n, input logic [31:0] rdat);
    for (int i = 0; i < n; i++) begin
      next_cyc;
      wb_ack_i = 1'b0; stall_i = 1'b1; wb_dat_i = 32'h0BAD_F00D;
      @(negedge clk);
      chk("ws_state", dut.state_q, S_WAIT);
      chk("ws_data", cpu_data_o, rdat);
      chk("ws_stallreq", {31'd0, stallreq_o}, 32'd0);
      chk("ws_cyc", {31'd0, wb_cyc_o}, 32'd0);
    end
    next_cyc;
    stall_i = 1'b0;
    @(negedge clk);
    chk("ws_last_state", dut.state_q, S_WAIT);
    chk("ws_last_data", cpu_data_o, rdat);
    idle_check;
  endtask

  task automatic abort_mid(input logic use_rst);
    next_cyc;
    cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h0000_0300;
    cpu_sel_i = 4'b1100; cpu_data_i = 32'hAABB_0000;
    @(negedge clk);
    chk("ab_req_stallreq", {31'd0, stallreq_o}, 32'd1);
    next_cyc;
    @(negedge clk);
    chk("ab_busy1_stb", {31'd0, wb_stb_o}, 32'd1);
    next_cyc;
    if (use_rst) rst = 1'b0;
    else flush_i = 1'b1;
    @(negedge clk);
    chk("ab_busy2_state", dut.state_q, S_BUSY);
    if (!use_rst) chk("ab_flush_stallreq", {31'd0, stallreq_o}, 32'd0);
    next_cyc;
    rst = 1'b1; flush_i = 1'b0; cpu_ce_i = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'h0000_0055;
    @(negedge clk);
    chk("ab_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("ab_stb", {31'd0, wb_stb_o}, 32'd0);
    chk("ab_adr", wb_adr_o, 32'd0);
    chk("ab_dat", wb_dat_o, 32'd0);
    chk("ab_sel", {28'd0, wb_sel_o}, 32'd0);
    chk("ab_we", {31'd0, wb_we_o}, 32'd0);
    chk("ab_state", dut.state_q, S_IDLE);
    chk("ab_bus_err", {31'd0, bus_err_o}, 32'd0);
    chk("ab_late_ack_data", cpu_data_o, 32'd0);
    next_cyc;
    wb_ack_i = 1'b0;
    @(negedge clk);
    chk("ab_after_state", dut.state_q, S_IDLE);
    chk("ab_after_cyc", {31'd0, wb_cyc_o}, 32'd0);
  endtask

  task automatic timeout_case;
    exp_q.push_back('{err: 1'b1, we: 1'b0, adr: 32'h0, sel: 4'h0, wdat: 32'h0, rdat: 32'h0});
    next_cyc;
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0400;
    cpu_sel_i = 4'b1111; cpu_data_i = 32'd0; wb_ack_i = 1'b0;
    @(negedge clk);
    chk("to_req_stallreq", {31'd0, stallreq_o}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      next_cyc;
      @(negedge clk);
      chk("to_stb", {31'd0, wb_stb_o}, 32'd1);
      chk("to_stallreq", {31'd0, stallreq_o}, (i < 4) ? 32'd1 : 32'd0);
      chk("to_data", cpu_data_o, 32'd0);
      chk("to_no_err_yet", {31'd0, bus_err_o}, 32'd0);
    end
    next_cyc;
    cpu_ce_i = 1'b0;
    @(negedge clk);
    chk("to_err_pulse", {31'd0, bus_err_o}, 32'd1);
    chk("to_stb_drop", {31'd0, wb_stb_o}, 32'd0);
    chk("to_cyc_drop", {31'd0, wb_cyc_o}, 32'd0);
    chk("to_state", dut.state_q, S_IDLE);
    next_cyc;
    @(negedge clk);
    chk("to_err_one_cycle", {31'd0, bus_err_o}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual no finish required finish by 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; cpu_ce_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_sel_i = '0;
    cpu_data_i = '0; stall_i = 1'b0; flush_i = 1'b0; wb_dat_i = '0; wb_ack_i = 1'b0;
    next_cyc;
    next_cyc;
    @(negedge clk);
    chk("rst_state", dut.state_q, S_IDLE);
    chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("rst_stb", {31'd0, wb_stb_o}, 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_sel", {28'd0, wb_sel_o}, 32'd0);
    chk("rst_we", {31'd0, wb_we_o}, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err_o}, 32'd0);
    chk("rst_data", cpu_data_o, 32'd0);
    next_cyc;
    rst = 1'b1;

    access(1'b0, 32'h0000_0104, 4'b1111, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);
    idle_check;
    access(1'b1, 32'h0000_0203, 4'b0001, 32'h0000_00A5, 1, 32'hFFFF_FFFF, 1'b0);
    idle_check;
    access(1'b0, 32'h0000_0108, 4'b1111, 32'h0, 1, 32'h1234_5678, 1'b1);
    wait_stall(3, 32'h1234_5678);
    timeout_case;
    abort_mid(1'b0);
    abort_mid(1'b1);
    access(1'b0, 32'h0000_0010, 4'b1111, 32'h0, 0, 32'h0000_0011, 1'b0);
    access(1'b0, 32'h0000_0014, 4'b1111, 32'h0, 0, 32'h0000_0022, 1'b0);
    idle_check;
    next_cyc;
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_wishbone_if.md
Name: dmem_wishbone_if

Overview:
- Data-side bus master that sits directly downstream of the MEM stage.
- Turns the MEM stage's single-cycle memory request (mem_addr/mem_we/mem_sel/mem_data/mem_ce) into a multi-cycle Wishbone-classic transaction.
- Returns the read word to the MEM stage on its mem_data_i input.
- Raises a stall request to pipeline control until the transaction completes.
- Holds the returned word while another stage keeps the pipeline frozen, and aborts hung transactions with a timeout.

Parameters:
- DATA_W, 32, data/address bus width (matches RegBus).
- TIMEOUT, 255, cycles in BUSY without ack before abort; legal range 2..65535.
- CNT_W, 16, width of the timeout counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on posedge clk).
- cpu_ce_i  in  1  request valid from MEM stage (mem_ce_o).
- cpu_we_i  in  1  1 = write (mem_we_o).
- cpu_addr_i  in  32  byte address (mem_addr_o).
- cpu_sel_i  in  4  byte lane select, bit3 = bits[31:24] (mem_sel_o).
- cpu_data_i  in  32  write data, already lane-positioned (mem_data_o).
- cpu_data_o  out  32  read data to MEM stage (mem_data_i).
- stall_i  in  1  pipeline frozen this cycle by pipeline control.
- flush_i  in  1  pipeline flush (exception).
- stallreq_o  out  1  stall request to pipeline control.
- bus_err_o  out  1  one-cycle pulse when a transaction times out.
- wb_adr_o  out  32  Wishbone address.
- wb_dat_o  out  32  Wishbone write data.
- wb_dat_i  in  32  Wishbone read data.
- wb_sel_o  out  4  Wishbone byte select.
- wb_we_o  out  1  Wishbone write enable.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_ack_i  in  1  Wishbone acknowledge.

Behaviour:
- Reset (rst==0 at posedge):
  - state = IDLE.
  - wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o are all 0.
  - Read buffer rd_buf = 0, timeout counter = 0, bus_err_o = 0.
  - Reset mid-transaction drops cyc/stb on the next edge with no completion.
- All wb_* outputs and bus_err_o are registered. cpu_data_o and stallreq_o are combinational.
- IDLE:
  - If cpu_ce_i=1 and flush_i=0: register cpu_addr/data/sel/we onto wb_adr/dat/sel/we, set cyc=stb=1, clear counter, go BUSY.
  - Otherwise stay in IDLE.
- BUSY, wb_ack_i=1:
  - Clear cyc, stb, we, adr, dat and sel to 0.
  - rd_buf <= wb_dat_i on a read; rd_buf <= 0 on a write.
  - Next state is WAIT_STALL if stall_i=1, else IDLE.
- BUSY, no ack, counter==TIMEOUT-1:
  - Abort: clear wb_* as for ack, rd_buf <= 0, bus_err_o <= 1 for one cycle.
  - Next state follows the same stall_i rule as ack.
- BUSY, no ack, otherwise: counter += 1, hold all wb_* signals stable.
- BUSY, flush_i=1: abort immediately (clear wb_*, go IDLE, no bus_err_o). flush_i has priority over ack.
- WAIT_STALL:
  - Ignore cpu_ce_i; never re-issue the request.
  - Hold rd_buf.
  - Go IDLE on the first cycle with stall_i=0, or immediately on flush_i=1.
- cpu_data_o:
  - In BUSY with wb_ack_i=1 (and not a write): wb_dat_i, same cycle.
  - In WAIT_STALL: rd_buf.
  - Otherwise: 0.
- stallreq_o = 1 when either:
  - (IDLE and cpu_ce_i and not flush_i), or
  - (BUSY and not wb_ack_i and not timeout-expiry-cycle and not flush_i).
  - 0 in all other cases, including WAIT_STALL.
- Latency: a request seen in cycle N drives cyc/stb from N+1. An ack in cycle M releases the stall in cycle M, so the pipeline advances at the end of M. Minimum two cycles per access.
- Back-to-back accesses: the next request is accepted in IDLE on the cycle after completion. There is never more than one outstanding transaction.
- wb_ack_i outside BUSY is ignored.

Test Plan:
- Single read: after rst=0 then 1, drive ce=1, we=0, addr=0x0000_0104, sel=4'b1111; slave acks 3 cycles after stb with 0xDEADBEEF.
  -> stallreq high 4 cycles; cpu_data_o=0xDEADBEEF in the ack cycle; cyc/stb low the next cycle; state IDLE.
- Byte write: ce=1, we=1, addr=0x0000_0203, sel=4'b0001, data=0x0000_00A5; ack after 1 cycle.
  -> wb_adr=0x203, wb_sel=0001, wb_we=1, wb_dat=0xA5 held stable until ack; no further strobe.
- Ack under external stall: read returns 0x1234_5678 while stall_i=1 for 3 more cycles.
  -> WAIT_STALL; cpu_data_o=0x1234_5678 for those 3 cycles; stallreq=0; no second cyc.
- Timeout: TIMEOUT=4, slave never acks.
  -> stb high 4 cycles, then drops; bus_err_o=1 for exactly one cycle; cpu_data_o=0; stallreq released in the expiry cycle.
- Flush and reset mid-access:
  - flush_i=1 in the 2nd BUSY cycle -> cyc/stb=0 next cycle, IDLE, no bus_err.
  - Repeat with rst=0 instead -> all wb_* outputs 0 next edge.
  - A late wb_ack_i is ignored in both cases.
- Back-to-back: two reads with immediate ack (0x11, 0x22) -> stb pulses in non-adjacent cycles; each value appears on cpu_data_o in its ack cycle.
